// File: rtl/apple1_term_fifo_io_if.sv
// CPU-side bus between the 6502 core and the Apple-1 terminal I/O block.
// The master drives address/strobes; the slave answers with hit and registered read data.
interface apple1_term_fifo_io_if;
    logic [15:0] address_bus;
    logic [7:0]  wdata;
    logic        mem_read;
    logic        mem_write;
    logic        hit;
    logic [7:0]  rdata;

    modport master (
        output address_bus, wdata, mem_read, mem_write,
        input  hit, rdata
    );

    modport slave (
        input  address_bus, wdata, mem_read, mem_write,
        output hit, rdata
    );
endinterface

// File: rtl/apple1_term_fifo_io.sv
// Apple-1 terminal I/O: KBD/KBDCR/DSP/DSPCR registers backed by RX (keyboard) and TX (display) FIFOs.
// Optional macro TERM_UPCASE_EN folds lowercase keystrokes to uppercase before they enter the RX FIFO.
module apple1_term_fifo_io #(
    parameter logic [15:0] BASE_ADDR = 16'hD010,
    parameter int          RX_DEPTH  = 8,
    parameter int          TX_DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    apple1_term_fifo_io_if.slave      bus,
    input  logic                      kbd_stb,
    input  logic [6:0]                kbd_data,
    output logic                      dsp_valid,
    output logic [6:0]                dsp_data,
    input  logic                      dsp_ready,
    output logic [$clog2(RX_DEPTH):0] rx_count,
    output logic [$clog2(TX_DEPTH):0] tx_count,
    output logic                      rx_ovf
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);

    logic [6:0]       rx_mem [RX_DEPTH];
    logic [6:0]       tx_mem [TX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;

    logic [1:0] reg_sel;
    logic       rd_en, wr_en;
    logic       rx_empty, rx_full, tx_empty, tx_full;
    logic       rx_pop, rx_push, ovf_set, ovf_clr;
    logic       tx_pop, tx_push;
    logic [6:0] kbd_char;

    // 17-bit compare so a base near the top of memory cannot wrap into a false hit.
    assign bus.hit = ({1'b0, bus.address_bus} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, bus.address_bus} <= ({1'b0, BASE_ADDR} + 17'd3));

    assign reg_sel  = bus.address_bus[1:0] - BASE_ADDR[1:0];
    assign rd_en    = bus.hit && bus.mem_read && !bus.mem_write;
    assign wr_en    = bus.hit && bus.mem_write;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == RX_FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_FULL_CNT);

    // A KBD read in the same cycle frees a slot, so a strobe into a full FIFO is still accepted.
    assign rx_pop   = rd_en && (reg_sel == 2'd0) && !rx_empty;
    assign rx_push  = kbd_stb && (!rx_full || rx_pop);
    assign ovf_set  = kbd_stb && rx_full && !rx_pop;
    assign ovf_clr  = wr_en && (reg_sel == 2'd1);

    assign tx_pop   = !tx_empty && dsp_ready;
    assign tx_push  = wr_en && (reg_sel == 2'd2) && (!tx_full || tx_pop);

    assign dsp_valid = !tx_empty;
    assign dsp_data  = tx_empty ? 7'd0 : tx_mem[tx_rd_ptr];

    always_comb begin
        kbd_char = kbd_data;
`ifdef TERM_UPCASE_EN
        if (kbd_data >= 7'h61 && kbd_data <= 7'h7A)
            kbd_char = kbd_data - 7'h20;
`endif
    end

    // Storage needs no reset: counts gate every use of stale entries.
    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr_ptr] <= kbd_char;
        if (tx_push)
            tx_mem[tx_wr_ptr] <= bus.wdata[6:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            rx_ovf    <= 1'b0;
            bus.rdata <= 8'h00;
        end else begin
            if (rx_push)
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (rx_push && !rx_pop)
                rx_count <= rx_count + 1'b1;
            else if (!rx_push && rx_pop)
                rx_count <= rx_count - 1'b1;

            if (tx_push)
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (tx_push && !tx_pop)
                tx_count <= tx_count + 1'b1;
            else if (!tx_push && tx_pop)
                tx_count <= tx_count - 1'b1;

            if (ovf_set)
                rx_ovf <= 1'b1;
            else if (ovf_clr)
                rx_ovf <= 1'b0;

            // Bit 7 of DSP reads as busy so WozMon's BMI poll loop waits on a full TX FIFO.
            if (rd_en) begin
                case (reg_sel)
                    2'd0:    bus.rdata <= rx_empty ? 8'h00 : {1'b1, rx_mem[rx_rd_ptr]};
                    2'd1:    bus.rdata <= {!rx_empty, rx_ovf, 6'b0};
                    2'd2:    bus.rdata <= {tx_full, 7'b0};
                    default: bus.rdata <= 8'h00;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_apple1_term_fifo_io.sv
// Self-checking bench for apple1_term_fifo_io: directed scenarios then a random phase against a queue-based model.
// Honors TERM_UPCASE_EN the same way the design does.
module tb_apple1_term_fifo_io;
    localparam logic [15:0] BASE = 16'hD010;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       kbd_stb = 1'b0;
    logic [6:0] kbd_data = 7'd0;
    logic       dsp_valid;
    logic [6:0] dsp_data;
    logic       dsp_ready = 1'b0;
    logic [3:0] rx_count;
    logic [3:0] tx_count;
    logic       rx_ovf;

    apple1_term_fifo_io_if bus();

    apple1_term_fifo_io dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .kbd_stb   (kbd_stb),
        .kbd_data  (kbd_data),
        .dsp_valid (dsp_valid),
        .dsp_data  (dsp_data),
        .dsp_ready (dsp_ready),
        .rx_count  (rx_count),
        .tx_count  (tx_count),
        .rx_ovf    (rx_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: plain queues plus the sticky flag and last read value.
    logic [6:0] rx_q[$];
    logic [6:0] tx_q[$];
    logic       ovf_m = 1'b0;
    logic [7:0] rdata_m = 8'h00;
    logic       ready = 1'b0;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check_output("rdata", bus.rdata, rdata_m);
        check_output("rx_count", rx_count, 16'(rx_q.size()));
        check_output("tx_count", tx_count, 16'(tx_q.size()));
        check_output("rx_ovf", rx_ovf, ovf_m);
        check_output("dsp_valid", dsp_valid, tx_q.size() != 0);
        check_output("dsp_data", dsp_data, (tx_q.size() != 0) ? tx_q[0] : 7'd0);
    endtask

    // One clock: drive inputs, predict from the register map, clock, compare.
    task automatic apply_stimulus(input logic [15:0] addr, input logic rd, input logic wr,
                                  input logic [7:0] wd, input logic stb, input logic [6:0] kd);
        logic       hit_m, rd_e, wr_e, pop_rx, pop_tx, rx_was_full, tx_was_full;
        logic [1:0] off;
        logic [6:0] c;
        bus.address_bus = addr;
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        bus.wdata       = wd;
        kbd_stb         = stb;
        kbd_data        = kd;
        dsp_ready       = ready;
        #1;
        hit_m = (addr >= BASE) && (addr <= BASE + 16'd3);
        check_output("hit", bus.hit, hit_m);
        off  = 2'(addr - BASE);
        rd_e = hit_m && rd && !wr;
        wr_e = hit_m && wr;
        rx_was_full = (rx_q.size() == 8);
        tx_was_full = (tx_q.size() == 8);
        pop_rx = rd_e && off == 2'd0 && rx_q.size() != 0;
        pop_tx = ready && tx_q.size() != 0;
        if (rd_e) begin
            case (off)
                2'd0:    rdata_m = (rx_q.size() != 0) ? {1'b1, rx_q[0]} : 8'h00;
                2'd1:    rdata_m = {rx_q.size() != 0, ovf_m, 6'b0};
                2'd2:    rdata_m = {tx_was_full, 7'b0};
                default: rdata_m = 8'h00;
            endcase
        end
        if (pop_rx)
            void'(rx_q.pop_front());
        if (wr_e && off == 2'd1)
            ovf_m = 1'b0;
        if (stb) begin
            c = kd;
`ifdef TERM_UPCASE_EN
            if (c >= 7'h61 && c <= 7'h7A)
                c = c - 7'h20;
`endif
            if (rx_was_full && !pop_rx)
                ovf_m = 1'b1;
            else
                rx_q.push_back(c);
        end
        if (pop_tx)
            void'(tx_q.pop_front());
        if (wr_e && off == 2'd2 && (!tx_was_full || pop_tx))
            tx_q.push_back(wd[6:0]);
        @(posedge clk);
        #1;
        check_model();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        kbd_stb       = 1'b0;
    endtask

    task automatic key(input logic [6:0] kd);
        apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, kd);
    endtask

    task automatic reg_read(input logic [1:0] off);
        apply_stimulus(BASE + 16'(off), 1'b1, 1'b0, 8'h00, 1'b0, 7'd0);
    endtask

    task automatic reg_write(input logic [1:0] off, input logic [7:0] wd);
        apply_stimulus(BASE + 16'(off), 1'b0, 1'b1, wd, 1'b0, 7'd0);
    endtask

    task automatic idle();
        apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 7'd0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        kbd_stb       = 1'b0;
        reset_n       = 1'b0;
        #2;
        rx_q.delete();
        tx_q.delete();
        ovf_m   = 1'b0;
        rdata_m = 8'h00;
        check_output("reset_rx_count", rx_count, 16'd0);
        check_output("reset_tx_count", tx_count, 16'd0);
        check_output("reset_rdata", bus.rdata, 16'h00);
        check_output("reset_dsp_valid", dsp_valid, 16'd0);
        check_output("reset_dsp_data", dsp_data, 16'd0);
        check_output("reset_rx_ovf", rx_ovf, 16'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0]  kbd_exp [6];
        logic [6:0]  msg [6];
        logic [15:0] addr;
        logic        rd, wr, stb;

        bus.address_bus = 16'h0000;
        bus.wdata       = 8'h00;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] scenario: WozMon-style keyboard read");
        do_reset();
        msg = '{7'h45, 7'h30, 7'h30, 7'h30, 7'h52, 7'h0D};
        kbd_exp = '{8'hC5, 8'hB0, 8'hB0, 8'hB0, 8'hD2, 8'h8D};
        for (int i = 0; i < 6; i++) key(msg[i]);
        reg_read(2'd1);
        check_output("kbdcr_ready", bus.rdata, 16'h80);
        for (int i = 0; i < 6; i++) begin
            reg_read(2'd0);
            check_output($sformatf("kbd_%0d", i), bus.rdata, 16'(kbd_exp[i]));
        end
        reg_read(2'd1);
        check_output("kbdcr_empty", bus.rdata, 16'h00);

        $display("[TB] scenario: keyboard overflow");
        do_reset();
        for (int i = 0; i < 9; i++) key(7'h41 + 7'(i));
        check_output("ovf_count", rx_count, 16'd8);
        check_output("ovf_flag", rx_ovf, 16'd1);
        reg_read(2'd1);
        check_output("ovf_kbdcr", bus.rdata, 16'hC0);
        reg_write(2'd1, 8'h5A);
        check_output("ovf_cleared", rx_ovf, 16'd0);
        for (int i = 0; i < 8; i++) begin
            reg_read(2'd0);
            check_output($sformatf("ovf_key_%0d", i), bus.rdata, 16'h80 | 16'(8'h41 + 8'(i)));
        end

        $display("[TB] scenario: display FIFO back-pressure");
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 8; i++) reg_write(2'd2, 8'h41 + 8'(i));
        check_output("tx_full_count", tx_count, 16'd8);
        reg_read(2'd2);
        check_output("dsp_busy", bus.rdata, 16'h80);
        reg_write(2'd2, 8'h49);
        check_output("tx_drop_count", tx_count, 16'd8);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 7'd0);
        end
        reg_read(2'd2);
        check_output("dsp_idle", bus.rdata, 16'h00);
        check_output("tx_drained", dsp_valid, 16'd0);

        $display("[TB] scenario: display order check");
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 8; i++) reg_write(2'd2, 8'h41 + 8'(i));
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("dsp_order_%0d", i), dsp_data, 16'(7'h41 + 7'(i)));
            idle();
        end

        $display("[TB] scenario: full RX, simultaneous read and strobe");
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 8; i++) key(7'h31 + 7'(i));
        apply_stimulus(BASE, 1'b1, 1'b0, 8'h00, 1'b1, 7'h5A);
        check_output("simul_rdata", bus.rdata, 16'hB1);
        check_output("simul_count", rx_count, 16'd8);
        check_output("simul_ovf", rx_ovf, 16'd0);
        for (int i = 0; i < 8; i++) reg_read(2'd0);
        check_output("simul_last", bus.rdata, 16'hDA);

        $display("[TB] scenario: reset mid-stream");
        do_reset();
        for (int i = 0; i < 3; i++) key(7'h58 + 7'(i));
        reg_write(2'd2, 8'h31);
        reg_read(2'd0);
        do_reset();
        check_output("midreset_count", rx_count, 16'd0);
        check_output("midreset_rdata", bus.rdata, 16'h00);
        check_output("midreset_valid", dsp_valid, 16'd0);
        reg_read(2'd0);
        check_output("midreset_kbd", bus.rdata, 16'h00);

        $display("[TB] scenario: lowercase keystroke");
        do_reset();
        key(7'h72);
        reg_read(2'd0);
`ifdef TERM_UPCASE_EN
        check_output("lower_r", bus.rdata, 16'hD2);
`else
        check_output("lower_r", bus.rdata, 16'hF2);
`endif

        $display("[TB] scenario: random traffic");
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0)
                addr = ($urandom_range(0, 1) == 0) ? (BASE - 16'($urandom_range(1, 4)))
                                                   : (BASE + 16'($urandom_range(4, 7)));
            else
                addr = BASE + 16'($urandom_range(0, 3));
            rd    = ($urandom_range(0, 2) == 0);
            wr    = ($urandom_range(0, 3) == 0);
            stb   = ($urandom_range(0, 2) == 0);
            ready = ($urandom_range(0, 3) == 0);
            apply_stimulus(addr, rd, wr, 8'($urandom), stb, 7'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
